// File: rtl/n_s_acq_arbiter.sv
// Noise/signal acquisition path arbiter: owns the shared ADC path-select line and
// serialises grants with a settle gap after every path switch and a drain gap after every release.
module n_s_acq_arbiter #(
    parameter int SETTLE_CYC = 8,
    parameter int DRAIN_CYC  = 4,
    parameter int MAX_GNT    = 65535,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic n_req,
    input  logic n_done,
    input  logic s_req,
    input  logic s_done,
    output logic n_gnt,
    output logic s_gnt,
    output logic n_s_ctrl,
    output logic busy,
    output logic timeout_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GRANT  = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [7:0]       DRAIN_LAST  = 8'(DRAIN_CYC - 1);
    localparam logic [7:0]       PHASE_MAX   = 8'hFF;
    localparam logic [CNT_W-1:0] WD_MAX      = CNT_W'(MAX_GNT);
    localparam logic [CNT_W-1:0] WD_ONE      = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             last_n_q, last_n_d;
    logic             win_n_q, win_n_d;
    logic             n_gnt_q, n_gnt_d;
    logic             s_gnt_q, s_gnt_d;
    logic             ctrl_q, ctrl_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;

    logic win_n;
    logic own_done;
    logic own_req;
    logic wd_expired;

    // On a tie the side that was not served last wins; N counts as last served after reset.
    assign win_n      = n_req & ~(s_req & last_n_q);
    assign own_done   = n_gnt_q ? n_done : s_done;
    assign own_req    = n_gnt_q ? n_req : s_req;
    assign wd_expired = (wd_q == WD_MAX);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        wd_d     = wd_q;
        last_n_d = last_n_q;
        win_n_d  = win_n_q;
        n_gnt_d  = n_gnt_q;
        s_gnt_d  = s_gnt_q;
        ctrl_d   = ctrl_q;
        to_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (n_req || s_req) begin
                    win_n_d = win_n;
                    if (win_n == ctrl_q) begin
                        state_d = ST_GRANT;
                        n_gnt_d = win_n;
                        s_gnt_d = ~win_n;
                        wd_d    = WD_ONE;
                    end else begin
                        state_d = ST_SETTLE;
                        ctrl_d  = win_n;
                        phase_d = '0;
                    end
                end
            end
            ST_SETTLE: begin
                // The winner was committed in IDLE; request changes here are ignored.
                if (phase_q == SETTLE_LAST) begin
                    state_d = ST_GRANT;
                    n_gnt_d = win_n_q;
                    s_gnt_d = ~win_n_q;
                    wd_d    = WD_ONE;
                end else if (phase_q != PHASE_MAX) begin
                    phase_d = phase_q + 8'd1;
                end
            end
            ST_GRANT: begin
                if (own_done || !own_req || wd_expired) begin
                    state_d  = ST_DRAIN;
                    phase_d  = '0;
                    last_n_d = n_gnt_q;
                    n_gnt_d  = 1'b0;
                    s_gnt_d  = 1'b0;
                    // Only a release caused purely by the watchdog is reported.
                    to_d     = wd_expired & own_req & ~own_done;
                end else if (!wd_expired) begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            default: begin
                if (phase_q == DRAIN_LAST) begin
                    state_d = ST_IDLE;
                end else if (phase_q != PHASE_MAX) begin
                    phase_d = phase_q + 8'd1;
                end
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            wd_q     <= '0;
            last_n_q <= 1'b1;
            win_n_q  <= 1'b0;
            n_gnt_q  <= 1'b0;
            s_gnt_q  <= 1'b0;
            ctrl_q   <= 1'b0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            wd_q     <= wd_d;
            last_n_q <= last_n_d;
            win_n_q  <= win_n_d;
            n_gnt_q  <= n_gnt_d;
            s_gnt_q  <= s_gnt_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
            to_q     <= to_d;
        end
    end

    assign n_gnt       = n_gnt_q;
    assign s_gnt       = s_gnt_q;
    assign n_s_ctrl    = ctrl_q;
    assign busy        = busy_q;
    assign timeout_err = to_q;

endmodule
